// File: rtl/argmax_classifier_if.sv
// Input-side bundle of the argmax classifier: activation vector, threshold and
// the valid/ready handshake that moves them into the block.
interface argmax_classifier_if #(
    parameter int NUM_CLASSES = 128,
    parameter int ACTIV_BITS  = 8
);
    logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in;
    logic                              data_valid;
    logic                              in_ready;
    logic [ACTIV_BITS-1:0]             threshold;

    modport master (
        output data_in,
        output data_valid,
        output threshold,
        input  in_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  threshold,
        output in_ready
    );
endinterface

// File: rtl/argmax_classifier.sv
// Captures an activation vector, scans it LANES elements per cycle and reports
// the index/value of the maximum plus a threshold-based detect flag.
module argmax_classifier #(
    parameter  int NUM_CLASSES = 128,
    parameter  int ACTIV_BITS  = 8,
    parameter  int LANES       = 4,
    localparam int CLASS_BITS  = $clog2(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    argmax_classifier_if.slave    bus,
    output logic [CLASS_BITS-1:0] class_out,
    output logic [ACTIV_BITS-1:0] score_out,
    output logic                  detect,
    output logic                  class_valid,
    output logic [7:0]            drop_count
);

    localparam int N        = NUM_CLASSES / LANES;
    localparam int GRP_BITS = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                          state;
    state_t                          next_state;
    logic [NUM_CLASSES*ACTIV_BITS-1:0] buf_q;
    logic [ACTIV_BITS-1:0]           thr_q;
    logic [ACTIV_BITS-1:0]           best_val;
    logic [CLASS_BITS-1:0]           best_idx;
    logic [GRP_BITS-1:0]             grp;
    logic [ACTIV_BITS-1:0]           cand_val;
    logic [CLASS_BITS-1:0]           cand_idx;
    logic                            accept;
    logic                            last_grp;

    assign bus.in_ready = (state == IDLE);
    assign accept       = (state == IDLE) && bus.data_valid;
    assign last_grp     = (grp == GRP_BITS'(N - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.data_valid) next_state = SCAN;
            SCAN:    if (last_grp)       next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lanes are walked in ascending index order with a strict compare, so the
    // lowest index wins any tie, both within a group and across groups.
    always_comb begin
        logic [ACTIV_BITS-1:0] elem;
        elem     = '0;
        cand_val = best_val;
        cand_idx = best_idx;
        for (int l = 0; l < LANES; l++) begin
            elem = buf_q[(int'(grp) * LANES + l) * ACTIV_BITS +: ACTIV_BITS];
            if (elem > cand_val) begin
                cand_val = elem;
                cand_idx = CLASS_BITS'(int'(grp) * LANES + l);
            end
        end
    end

    // The vector copy needs no reset; a new scan always starts from a fresh capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            thr_q       <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            grp         <= '0;
            class_out   <= '0;
            score_out   <= '0;
            detect      <= 1'b0;
            class_valid <= 1'b0;
            drop_count  <= '0;
        end else begin
            state       <= next_state;
            class_valid <= 1'b0;
            if (bus.data_valid && !bus.in_ready && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (accept) begin
                thr_q    <= bus.threshold;
                best_val <= '0;
                best_idx <= '0;
                grp      <= '0;
            end else if (state == SCAN) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                grp      <= grp + 1'b1;
                if (last_grp) begin
                    class_out   <= cand_idx;
                    score_out   <= cand_val;
                    detect      <= (cand_val >= thr_q);
                    class_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier with default parameters.
module tb_argmax_classifier;

    localparam int NUM_CLASSES = 128;
    localparam int ACTIV_BITS  = 8;
    localparam int LANES       = 4;
    localparam int VEC_BITS    = NUM_CLASSES * ACTIV_BITS;

    logic       clk;
    logic       rst;
    logic [6:0] class_out;
    logic [7:0] score_out;
    logic       detect;
    logic       class_valid;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    argmax_classifier_if #(.NUM_CLASSES(NUM_CLASSES), .ACTIV_BITS(ACTIV_BITS)) bus ();

    argmax_classifier #(
        .NUM_CLASSES(NUM_CLASSES),
        .ACTIV_BITS (ACTIV_BITS),
        .LANES      (LANES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .class_out  (class_out),
        .score_out  (score_out),
        .detect     (detect),
        .class_valid(class_valid),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Counts edges from the current point until class_valid is seen (bounded).
    task automatic waitResult(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!class_valid && n < 60);
    endtask

    // Offers one vector, scrambles the inputs after the accept edge, then checks the result.
    task automatic applyStimulus(input string tag, input logic [VEC_BITS-1:0] vec, input logic [7:0] thr,
                                 input int expClass, input int expScore, input int expDetect);
        int n;
        waitIdle(tag);
        bus.data_in    = vec;
        bus.threshold  = thr;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.data_in    = {NUM_CLASSES{8'hEE}};
        bus.threshold  = 8'hFF;
        waitResult(n);
        checkOutput({tag, "_latency"}, 32'(n), 32'd32);
        checkOutput({tag, "_class"}, 32'(class_out), 32'(expClass));
        checkOutput({tag, "_score"}, 32'(score_out), 32'(expScore));
        checkOutput({tag, "_detect"}, 32'(detect), 32'(expDetect));
        tick();
        checkOutput({tag, "_pulse_end"}, 32'(class_valid), 32'd0);
        checkOutput({tag, "_class_hold"}, 32'(class_out), 32'(expClass));
    endtask

    logic [VEC_BITS-1:0] vec;
    logic [VEC_BITS-1:0] vecB;

    initial begin
        int firstAcc;
        int secondAcc;
        int accN;
        int n;
        int stray;

        rst            = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.threshold  = '0;
        tick();
        tick();
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_class", 32'(class_out), 32'd0);
        checkOutput("reset_score", 32'(score_out), 32'd0);
        checkOutput("reset_detect", 32'(detect), 32'd0);
        checkOutput("reset_valid", 32'(class_valid), 32'd0);
        checkOutput("reset_drops", 32'(drop_count), 32'd0);
        rst = 1'b0;
        tick();

        vec = '0;
        vec[77*8 +: 8] = 8'd200;
        applyStimulus("single_peak", vec, 8'd150, 77, 200, 1);

        vec = {NUM_CLASSES{8'd10}};
        vec[5*8 +: 8]  = 8'd255;
        vec[90*8 +: 8] = 8'd255;
        applyStimulus("tie_low_index", vec, 8'd255, 5, 255, 1);

        vec = {NUM_CLASSES{8'd3}};
        vec[127*8 +: 8] = 8'd9;
        applyStimulus("last_lane", vec, 8'd10, 127, 9, 0);

        vec = '0;
        applyStimulus("all_zero_thr0", vec, 8'd0, 0, 0, 1);

        vec = {NUM_CLASSES{8'd100}};
        vec[64*8 +: 8] = 8'd250;
        vec[65*8 +: 8] = 8'd251;
        applyStimulus("adjacent_lanes", vec, 8'd252, 65, 251, 0);

        // Held data_valid: accepts at cycles 0 and 33, drops everywhere else while busy.
        waitIdle("hold");
        bus.data_in    = {NUM_CLASSES{8'd1}};
        bus.threshold  = 8'd0;
        bus.data_valid = 1'b1;
        accN      = 0;
        firstAcc  = -1;
        secondAcc = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) begin
                if (accN == 0) firstAcc = k;
                else if (accN == 1) secondAcc = k;
                accN++;
            end
            tick();
        end
        checkOutput("hold_accept_count", 32'(accN), 32'd2);
        checkOutput("hold_first_accept", 32'(firstAcc), 32'd0);
        checkOutput("hold_second_accept", 32'(secondAcc), 32'd33);
        checkOutput("hold_drops_38", 32'(drop_count), 32'd38);
        for (int k = 0; k < 400; k++) tick();
        checkOutput("drops_saturate", 32'(drop_count), 32'd255);
        bus.data_valid = 1'b0;
        tick();
        waitIdle("after_hold");

        // Abort a scan with reset partway through.
        vec = '0;
        vec[40*8 +: 8] = 8'd77;
        bus.data_in    = vec;
        bus.threshold  = 8'd1;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_class", 32'(class_out), 32'd0);
        checkOutput("abort_score", 32'(score_out), 32'd0);
        checkOutput("abort_detect", 32'(detect), 32'd0);
        checkOutput("abort_valid", 32'(class_valid), 32'd0);
        checkOutput("abort_drops", 32'(drop_count), 32'd0);
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (class_valid) stray++;
        end
        checkOutput("abort_no_result", 32'(stray), 32'd0);
        vec = {NUM_CLASSES{8'd20}};
        vec[99*8 +: 8] = 8'd21;
        applyStimulus("after_abort", vec, 8'd21, 99, 21, 1);

        // Back-to-back: second vector offered in the class_valid cycle of the first.
        waitIdle("b2b");
        vec = '0;
        vec[12*8 +: 8] = 8'd50;
        vecB = {NUM_CLASSES{8'd2}};
        vecB[113*8 +: 8] = 8'd180;
        bus.data_in    = vec;
        bus.threshold  = 8'd60;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        waitResult(n);
        checkOutput("b2b_a_latency", 32'(n), 32'd32);
        checkOutput("b2b_a_class", 32'(class_out), 32'd12);
        checkOutput("b2b_a_detect", 32'(detect), 32'd0);
        checkOutput("b2b_ready_in_valid", 32'(bus.in_ready), 32'd1);
        bus.data_in    = vecB;
        bus.threshold  = 8'd180;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        waitResult(n);
        checkOutput("b2b_b_spacing", 32'(n + 1), 32'd33);
        checkOutput("b2b_b_class", 32'(class_out), 32'd113);
        checkOutput("b2b_b_score", 32'(score_out), 32'd180);
        checkOutput("b2b_b_detect", 32'(detect), 32'd1);
        checkOutput("b2b_drops", 32'(drop_count), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
